channel_demux: RTL
==================

CHANNEL_DEMUX -- requirements
Module: channel_demux

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of channels per frame (a power of two).
REQ-002 The block SHALL have parameter LOGN, default 3, meaning log2(N).
REQ-003 The block SHALL have parameter WDTH, default 32, meaning the sample width (complex: real in the upper WDTH/2 bits, imaginary in the lower WDTH/2 bits).
REQ-004 The block SHALL have parameter MWDTH, default 1, meaning the sideband message width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_data, input, WDTH bits: channel sample from the interleaved channelized stream.
REQ-008 The block SHALL have port in_nd, input, 1 bit: in_data/in_m/in_first valid this cycle.
REQ-009 The block SHALL have port in_m, input, MWDTH bits: sideband message accompanying the sample.
REQ-010 The block SHALL have port in_first, input, 1 bit: high on the channel-0 sample of each frame.
REQ-011 The block SHALL have port sel_channel, input, LOGN bits: the channel to extract.
REQ-012 The block SHALL have port out_data, output, WDTH bits: extracted sample.
REQ-013 The block SHALL have port out_nd, output, 1 bit: out_data/out_m valid, single-cycle pulse.
REQ-014 The block SHALL have port out_m, output, MWDTH bits: message of the extracted sample.
REQ-015 The block SHALL have port locked, output, 1 bit: the block is frame-aligned.
REQ-016 The block SHALL have port error, output, 1 bit: sticky alignment error.

Function
REQ-017 The block SHALL have two states: HUNT (the reset state) and LOCK.
REQ-018 In HUNT, valid samples with in_first=0 SHALL be discarded, with no out_nd.
REQ-019 In HUNT, a valid sample with in_first=1 SHALL move the block to LOCK, set the channel counter to 1, and latch sel_channel into active_sel; that sample is treated as channel 0.
REQ-020 In LOCK, each valid sample SHALL carry channel number = counter; the counter increments by 1 mod N (wraps N-1 -> 0).
REQ-021 In LOCK, in_first=1 with counter != 0 SHALL set error, realign by treating the sample as channel 0, and set the counter to 1.
REQ-022 In LOCK, in_first=0 with counter == 0 SHALL set error, discard the sample, and return to HUNT.
REQ-023 active_sel SHALL be reloaded from sel_channel only on each accepted channel-0 sample; a sel_channel change mid-frame takes effect from the next frame, and the channel-0 sample itself uses the newly latched value.
REQ-024 When a sample is accepted in LOCK (or on HUNT->LOCK entry) with channel == active_sel, the next cycle SHALL show out_nd=1, with out_data=in_data and out_m=in_m (latency exactly 1 cycle).
REQ-025 out_nd SHALL be 0 in every other cycle; out_data/out_m SHALL hold their last value when out_nd=0.
REQ-026 Cycles with in_nd=0 SHALL change no state, and out_nd SHALL be 0 the following cycle.
REQ-027 locked SHALL be 1 exactly while the state is LOCK, registered, and SHALL update the cycle after the transition.
REQ-028 error SHALL remain 1 once set, until reset.
REQ-029 Back-to-back in_nd (every cycle) SHALL be sustained with no sample loss.

Reset
REQ-030 While rst_n=0, independent of clk: state=HUNT, counter=0, active_sel=0, out_data=0, out_m=0, out_nd=0, locked=0, error=0.
REQ-031 rst_n deasserted mid-frame SHALL discard partial-frame progress; the block then hunts for the next in_first.

Verification
REQ-032 Scenario, lock and extract: N=8, sel_channel=3, samples 0..15 every cycle with in_first on samples 0 and 8 -> out_nd on the cycles after samples 3 and 11, out_data=3 then 11, locked=1, error=0.
REQ-033 Scenario, hunt: 5 samples with in_first=0, then a frame with in_first on the first sample, sel=0 -> the first 5 are dropped, one output equal to the first frame sample, locked rises one cycle later.
REQ-034 Scenario, early first: in_first asserted at counter=5 -> error=1, that sample is treated as channel 0, and subsequent extraction uses the new alignment.
REQ-035 Scenario, missing first: at counter wrap to 0 a sample arrives with in_first=0 -> error=1, locked=0, no output until the next in_first.
REQ-036 Scenario, selection change: sel_channel changed 2->6 at counter=4 within a frame -> that frame outputs channel 2 only, the next frame outputs channel 6.
REQ-037 Scenario, gapped input and reset: random in_nd gaps give the same outputs as the gapless case; rst_n pulsed low mid-frame -> all outputs 0 immediately, block returns to HUNT.

Source files
------------

// File: rtl/channel_demux.sv
// Channel demultiplexer: aligns to the frame marker of an interleaved
// channelized stream and extracts the samples of one selected channel.
module channel_demux #(
  parameter int N     = 8,
  parameter int LOGN  = 3,
  parameter int WDTH  = 32,
  parameter int MWDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  input  logic             in_first,
  input  logic [LOGN-1:0]  sel_channel,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             locked,
  output logic             error
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [LOGN-1:0] CH0 = '0;
  localparam logic [LOGN-1:0] CH1 = LOGN'(1);

  state_t            state_q;
  state_t            state_d;
  logic [LOGN-1:0]   cnt_q;
  logic [LOGN-1:0]   cnt_d;
  logic [LOGN-1:0]   sel_q;
  logic [LOGN-1:0]   sel_d;
  logic [LOGN-1:0]   ch;
  logic              err_q;
  logic              err_d;
  logic              accept;
  logic              locked_q;

  logic              nd_q;
  logic              nd_d;
  logic [WDTH-1:0]   data_q;
  logic [WDTH-1:0]   data_d;
  logic [MWDTH-1:0]  m_q;
  logic [MWDTH-1:0]  m_d;

  logic              lk_first;
  logic              lk_miss;
  logic              lk_next;

  assign lk_first = in_first;
  assign lk_miss  = !in_first && (cnt_q == CH0);
  assign lk_next  = !in_first && (cnt_q != CH0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      nd_q     <= 1'b0;
      data_q   <= '0;
      m_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCK);
      nd_q     <= nd_d;
      data_q   <= data_d;
      m_q      <= m_d;
    end
  end

  // Channel tracking: a marked sample always restarts the frame at ch 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    ch      = cnt_q;
    accept  = 1'b0;
    if (in_nd) begin
      unique case (state_q)
        HUNT: begin
          if (in_first) begin
            state_d = LOCK;
            cnt_d   = CH1;
            sel_d   = sel_channel;
            ch      = CH0;
            accept  = 1'b1;
          end
        end
        LOCK: begin
          unique case (1'b1)
            lk_first: begin
              if (cnt_q != CH0) err_d = 1'b1;
              cnt_d  = CH1;
              sel_d  = sel_channel;
              ch     = CH0;
              accept = 1'b1;
            end
            lk_miss: begin
              err_d   = 1'b1;
              state_d = HUNT;
              cnt_d   = CH0;
            end
            lk_next: begin
              cnt_d  = cnt_q + CH1;
              accept = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // sel_d already carries the freshly latched selection on channel 0.
  always_comb begin
    nd_d   = accept && (ch == sel_d);
    data_d = data_q;
    m_d    = m_q;
    if (nd_d) begin
      data_d = in_data;
      m_d    = in_m;
    end
  end

  assign out_nd   = nd_q;
  assign out_data = data_q;
  assign out_m    = m_q;
  assign locked   = locked_q;
  assign error    = err_q;

endmodule
